// File: rtl/ifeed_pkg.sv
// Shared types for the west-border input feeder.
package ifeed_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        CLR   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Per-row border stage at the default operand width. The top builds the
    // same {en, clr, data} layout at its own WIDTH so rows stay bit-compatible.
    localparam int STAGE_WIDTH = 8;

    typedef struct packed {
        logic                   en;
        logic                   clr;
        logic [STAGE_WIDTH-1:0] data;
    } stage_t;

    localparam stage_t ZERO_STAGE = '0;

endpackage

// File: rtl/ifeed_border_skew_pipe.sv
// Depth-D delay line of one row stage {en, clr, data}; D must be >= 1.
module skew_pipe #(
    parameter int W = 10,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         active
);

    logic [W-1:0] pipe [D];

    // Shift the stage one position per cycle; reset empties the whole line.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < D; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            pipe[0] <= din;
            for (int k = 1; k < D; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    assign dout = pipe[D-1];

    // Any position still carrying an enable or clear keeps the feeder busy.
    always_comb begin
        active = 1'b0;
        for (int k = 0; k < D; k++) begin
            active = active | pipe[k][W-1] | pipe[k][W-2];
        end
    end

endmodule

// File: rtl/ifeed_border.sv
// West-border input feeder: holds each operand vector for L cycles, skews
// row r by r cycles, and ends a tile with a skewed clear wave.
//
// state | meaning
// IDLE  | no vector in flight, ready for a new one
// HOLD  | streaming captured vector; cnt counts remaining cycles
// CLR   | row 0 carries the clear pulse of the tile
// DRAIN | waiting ROWS-1 cycles for the clear wave to leave the skew
module ifeed_border
    import ifeed_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int ROWS     = 4,
    parameter int LEN_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [ROWS*WIDTH-1:0] i_data,
    input  logic [LEN_BITS-1:0]   i_len,
    input  logic                  i_last,
    output logic [ROWS*WIDTH-1:0] o_data,
    output logic [ROWS-1:0]       o_en,
    output logic [ROWS-1:0]       o_clr,
    output logic                  o_busy
);

    localparam int SW = WIDTH + 2;
    localparam logic [LEN_BITS-1:0] DRAIN_CNT =
        (ROWS > 1) ? LEN_BITS'(ROWS - 2) : '0;

    state_t                  state, state_n;
    logic [LEN_BITS-1:0]     cnt, cnt_n;
    logic                    last_q, last_n;
    // Launch registers feed every row; row r data travels with its own skew.
    logic                    launch_en, launch_en_n;
    logic                    launch_clr, launch_clr_n;
    logic [ROWS*WIDTH-1:0]   launch_data, launch_data_n;
    logic                    final_hold;
    logic                    hs;
    logic [ROWS-1:0]         pipe_active;

    assign final_hold = (state == HOLD) && (cnt == '0);
    assign i_ready    = !rst && ((state == IDLE) || final_hold);
    assign hs         = i_valid && i_ready;

    // State, counter, tile flag and launch stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            last_q      <= 1'b0;
            launch_en   <= 1'b0;
            launch_clr  <= 1'b0;
            launch_data <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            last_q      <= last_n;
            launch_en   <= launch_en_n;
            launch_clr  <= launch_clr_n;
            launch_data <= launch_data_n;
        end
    end

    // Next state and the stage value that row 0 shows in that next state.
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        last_n        = last_q;
        launch_en_n   = 1'b0;
        launch_clr_n  = 1'b0;
        launch_data_n = '0;
        case (state)
            IDLE: begin
                if (hs) begin
                    state_n       = HOLD;
                    cnt_n         = i_len;
                    last_n        = i_last;
                    launch_en_n   = 1'b1;
                    launch_data_n = i_data;
                end
            end
            HOLD: begin
                if (cnt != '0) begin
                    cnt_n         = cnt - LEN_BITS'(1);
                    launch_en_n   = 1'b1;
                    launch_data_n = launch_data;
                end else if (hs) begin
                    cnt_n         = i_len;
                    last_n        = i_last;
                    launch_en_n   = 1'b1;
                    launch_data_n = i_data;
                end else if (last_q) begin
                    state_n      = CLR;
                    launch_clr_n = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            CLR: begin
                if (ROWS == 1) begin
                    state_n = IDLE;
                end else begin
                    state_n = DRAIN;
                    cnt_n   = DRAIN_CNT;
                end
            end
            DRAIN: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - LEN_BITS'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [SW-1:0] row_in;
        logic [SW-1:0] row_out;

        assign row_in = {launch_en, launch_clr, launch_data[r*WIDTH +: WIDTH]};

        if (r == 0) begin : g_direct
            assign row_out        = row_in;
            assign pipe_active[r] = 1'b0;
        end else begin : g_skew
            skew_pipe #(
                .W (SW),
                .D (r)
            ) u_skew (
                .clk    (clk),
                .rst    (rst),
                .din    (row_in),
                .dout   (row_out),
                .active (pipe_active[r])
            );
        end

        assign o_en[r]                   = row_out[SW-1];
        assign o_clr[r]                  = row_out[SW-2];
        assign o_data[r*WIDTH +: WIDTH]  = row_out[WIDTH-1:0];
    end

    assign o_busy = (state != IDLE) || launch_en || launch_clr || (|pipe_active);

endmodule
